// File: rtl/regfile_operand_fetch.sv
// Operand fetch stage: issues RegisterFile reads/writes, tracks pending destinations
// in a scoreboard and presents operands to execute through a valid/ready handshake.
//
// state  | meaning
// S_IDLE | nothing held, out_valid low
// S_READ | read issued last cycle, operands come straight from rf_read_data
// S_HOLD | operands captured locally, waiting for out_ready
module regfile_operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_WIDTH-1:0]  in_sel_ra,
    input  logic [SEL_WIDTH-1:0]  in_sel_rb,
    input  logic [SEL_WIDTH-1:0]  in_sel_rc,
    input  logic                  in_dest_en,
    input  logic [SEL_WIDTH-1:0]  in_dest_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data_ra,
    output logic [DATA_WIDTH-1:0] out_data_rb,
    output logic [DATA_WIDTH-1:0] out_data_rc,
    output logic                  out_dest_en,
    output logic [SEL_WIDTH-1:0]  out_dest_sel,
    input  logic                  wb_valid,
    input  logic [SEL_WIDTH-1:0]  wb_sel,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic [SEL_WIDTH-1:0]  rf_read_sel_ra,
    output logic [SEL_WIDTH-1:0]  rf_read_sel_rb,
    output logic [SEL_WIDTH-1:0]  rf_read_sel_rc,
    input  logic [DATA_WIDTH-1:0] rf_read_data_ra,
    input  logic [DATA_WIDTH-1:0] rf_read_data_rb,
    input  logic [DATA_WIDTH-1:0] rf_read_data_rc,
    output logic                  rf_write_en,
    output logic [SEL_WIDTH-1:0]  rf_write_sel,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  sb_err
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d, pend_eff;
    logic [SEL_WIDTH-1:0]  held_ra_q, held_ra_d, held_rb_q, held_rb_d, held_rc_q, held_rc_d;
    logic                  dest_en_q, dest_en_d;
    logic [SEL_WIDTH-1:0]  dest_sel_q, dest_sel_d;
    logic [DATA_WIDTH-1:0] hold_ra_q, hold_ra_d, hold_rb_q, hold_rb_d, hold_rc_q, hold_rc_d;
    logic                  sb_err_q, sb_err_d;
    logic                  hazard, accept;

    assign rf_write_en   = wb_valid && (wb_sel != '0);
    assign rf_write_sel  = wb_sel;
    assign rf_write_data = wb_data;

    // The RegisterFile forwards same-cycle writes, so a source retiring now is safe to read.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_eff[i] = pending_q[i] && !(wb_valid && (wb_sel == SEL_WIDTH'(i)));
        end
    end

    assign hazard   = in_valid && (pend_eff[in_sel_ra] || pend_eff[in_sel_rb] ||
                      pend_eff[in_sel_rc] || (in_dest_en && pend_eff[in_dest_sel]));
    assign in_ready = rst_n && !hazard && !flush && ((state_q == S_IDLE) || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            held_ra_q  <= '0;
            held_rb_q  <= '0;
            held_rc_q  <= '0;
            dest_en_q  <= 1'b0;
            dest_sel_q <= '0;
            hold_ra_q  <= '0;
            hold_rb_q  <= '0;
            hold_rc_q  <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            held_ra_q  <= held_ra_d;
            held_rb_q  <= held_rb_d;
            held_rc_q  <= held_rc_d;
            dest_en_q  <= dest_en_d;
            dest_sel_q <= dest_sel_d;
            hold_ra_q  <= hold_ra_d;
            hold_rb_q  <= hold_rb_d;
            hold_rc_q  <= hold_rc_d;
            sb_err_q   <= sb_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = accept ? S_READ : S_IDLE;
                S_READ:  state_d = !out_ready ? S_HOLD : (accept ? S_READ : S_IDLE);
                S_HOLD:  state_d = !out_ready ? S_HOLD : (accept ? S_READ : S_IDLE);
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid      = (state_q != S_IDLE);
        out_data_ra    = '0;
        out_data_rb    = '0;
        out_data_rc    = '0;
        if (state_q == S_READ) begin
            out_data_ra = rf_read_data_ra;
            out_data_rb = rf_read_data_rb;
            out_data_rc = rf_read_data_rc;
        end else if (state_q == S_HOLD) begin
            out_data_ra = hold_ra_q;
            out_data_rb = hold_rb_q;
            out_data_rc = hold_rc_q;
        end
        out_dest_en    = dest_en_q;
        out_dest_sel   = dest_sel_q;
        sb_err         = sb_err_q;
        rf_read_sel_ra = accept ? in_sel_ra : held_ra_q;
        rf_read_sel_rb = accept ? in_sel_rb : held_rb_q;
        rf_read_sel_rc = accept ? in_sel_rc : held_rc_q;
    end

    always_comb begin
        held_ra_d  = held_ra_q;
        held_rb_d  = held_rb_q;
        held_rc_d  = held_rc_q;
        dest_en_d  = dest_en_q;
        dest_sel_d = dest_sel_q;
        hold_ra_d  = hold_ra_q;
        hold_rb_d  = hold_rb_q;
        hold_rc_d  = hold_rc_q;
        pending_d  = pending_q;
        sb_err_d   = sb_err_q;
        if (accept) begin
            held_ra_d  = in_sel_ra;
            held_rb_d  = in_sel_rb;
            held_rc_d  = in_sel_rc;
            dest_en_d  = in_dest_en;
            dest_sel_d = in_dest_sel;
        end
        // Capture before a later writeback can change the register under the held select.
        if ((state_q == S_READ) && !out_ready) begin
            hold_ra_d = rf_read_data_ra;
            hold_rb_d = rf_read_data_rb;
            hold_rc_d = rf_read_data_rc;
        end
        if (wb_valid) begin
            if (pending_q[wb_sel]) pending_d[wb_sel] = 1'b0;
            else                   sb_err_d = 1'b1;
        end
        if (accept && in_dest_en && (in_dest_sel != '0)) begin
            pending_d[in_dest_sel] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: emulates the RegisterFile, models the stage as a
// one-entry buffer plus a pending-register set, and compares every cycle.
module tb_regfile_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [3:0]  in_sel_ra = '0, in_sel_rb = '0, in_sel_rc = '0;
    logic        in_dest_en = 1'b0;
    logic [3:0]  in_dest_sel = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_data_ra, out_data_rb, out_data_rc;
    logic        out_dest_en;
    logic [3:0]  out_dest_sel;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic [3:0]  rf_read_sel_ra, rf_read_sel_rb, rf_read_sel_rc;
    logic [31:0] rf_read_data_ra = '0, rf_read_data_rb = '0, rf_read_data_rc = '0;
    logic        rf_write_en;
    logic [3:0]  rf_write_sel;
    logic [31:0] rf_write_data;
    logic        sb_err;

    int vecs = 0;
    int errs = 0;

    regfile_operand_fetch #(.DATA_WIDTH(32), .NUM_REGS(16), .SEL_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel_ra(in_sel_ra), .in_sel_rb(in_sel_rb), .in_sel_rc(in_sel_rc),
        .in_dest_en(in_dest_en), .in_dest_sel(in_dest_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data_ra(out_data_ra), .out_data_rb(out_data_rb), .out_data_rc(out_data_rc),
        .out_dest_en(out_dest_en), .out_dest_sel(out_dest_sel),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush),
        .rf_read_sel_ra(rf_read_sel_ra), .rf_read_sel_rb(rf_read_sel_rb),
        .rf_read_sel_rc(rf_read_sel_rc),
        .rf_read_data_ra(rf_read_data_ra), .rf_read_data_rb(rf_read_data_rb),
        .rf_read_data_rc(rf_read_data_rc),
        .rf_write_en(rf_write_en), .rf_write_sel(rf_write_sel), .rf_write_data(rf_write_data),
        .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    // RegisterFile emulation: synchronous read with same-cycle write bypass, r0 reads zero.
    logic [31:0] rf_mem [16];

    function automatic logic [31:0] rf_rd(input logic [3:0] s);
        if (s == 4'd0) return 32'd0;
        if (rf_write_en && rf_write_sel == s) return rf_write_data;
        return rf_mem[s];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= (i == 0) ? 32'd0 : $urandom;
        end else begin
            rf_read_data_ra <= rf_rd(rf_read_sel_ra);
            rf_read_data_rb <= rf_rd(rf_read_sel_rb);
            rf_read_data_rc <= rf_rd(rf_read_sel_rc);
            if (rf_write_en) rf_mem[rf_write_sel] <= rf_write_data;
        end
    end

    // Reference model: pending set, sticky error, one-entry output buffer.
    logic [15:0] m_pend;
    logic        m_err;
    logic        m_full;
    logic [31:0] m_ra, m_rb, m_rc;
    logic        m_de;
    logic [3:0]  m_ds;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic pe(input logic [3:0] s, input logic wv, input logic [3:0] ws);
        return m_pend[s] && !(wv && ws == s);
    endfunction

    function automatic logic [31:0] fv(input logic [3:0] s, input logic wv,
                                       input logic [3:0] ws, input logic [31:0] wd);
        if (s == 4'd0) return 32'd0;
        if (wv && ws == s) return wd;
        return rf_mem[s];
    endfunction

    task automatic model_clear();
        m_pend = '0; m_err = 1'b0; m_full = 1'b0;
        m_ra = '0; m_rb = '0; m_rc = '0; m_de = 1'b0; m_ds = '0;
    endtask

    // Called at posedge+1; drives one cycle, checks it, advances the model.
    task automatic step(input logic iv, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rc, input logic de, input logic [3:0] ds,
                        input logic ordy, input logic wbv, input logic [3:0] wbs,
                        input logic [31:0] wbd, input logic fl);
        logic haz, e_ready, acc, consume;
        logic [31:0] nra, nrb, nrc;
        in_valid = iv; in_sel_ra = ra; in_sel_rb = rb; in_sel_rc = rc;
        in_dest_en = de; in_dest_sel = ds; out_ready = ordy;
        wb_valid = wbv; wb_sel = wbs; wb_data = wbd; flush = fl;
        #4;
        haz = iv && (pe(ra, wbv, wbs) || pe(rb, wbv, wbs) || pe(rc, wbv, wbs) ||
                     (de && pe(ds, wbv, wbs)));
        e_ready = !haz && !fl && (!m_full || ordy);
        acc     = iv && e_ready;
        consume = m_full && ordy;
        chk("in_ready", in_ready, e_ready);
        chk("out_valid", out_valid, m_full);
        if (m_full) begin
            chk("out_data_ra", out_data_ra, m_ra);
            chk("out_data_rb", out_data_rb, m_rb);
            chk("out_data_rc", out_data_rc, m_rc);
            chk("out_dest_en", out_dest_en, m_de);
            if (m_de) chk("out_dest_sel", out_dest_sel, m_ds);
        end
        chk("rf_write_en", rf_write_en, wbv && wbs != 4'd0);
        if (wbv) begin
            chk("rf_write_sel", rf_write_sel, wbs);
            chk("rf_write_data", rf_write_data, wbd);
        end
        if (acc) chk("rf_read_sel", {rf_read_sel_ra, rf_read_sel_rb, rf_read_sel_rc}, {ra, rb, rc});
        chk("sb_err", sb_err, m_err);
        nra = fv(ra, wbv, wbs, wbd);
        nrb = fv(rb, wbv, wbs, wbd);
        nrc = fv(rc, wbv, wbs, wbd);
        @(posedge clk);
        if (wbv && !(wbs != 4'd0 && m_pend[wbs])) m_err = 1'b1;
        if (wbv) m_pend[wbs] = 1'b0;
        if (acc && de && ds != 4'd0) m_pend[ds] = 1'b1;
        if (fl) m_full = 1'b0;
        else if (acc) begin
            m_full = 1'b1; m_ra = nra; m_rb = nrb; m_rc = nrc; m_de = de; m_ds = ds;
        end else if (consume) m_full = 1'b0;
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, ordy, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst in_ready", in_ready, 1'b0);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_data_ra", out_data_ra, 32'd0);
        chk("rst out_dest", {out_dest_en, out_dest_sel}, 5'd0);
        chk("rst sb_err", sb_err, 1'b0);
        repeat (2) @(posedge clk);
        model_clear();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        apply_reset();

        // back-to-back independent ops
        step(1, 4'd1, 4'd2, 4'd0, 0, 4'd0, 1, 0, 4'd0, 32'd0, 0);
        step(1, 4'd3, 4'd4, 4'd0, 0, 4'd0, 1, 0, 4'd0, 32'd0, 0);
        idle(1'b1);
        idle(1'b1);

        // RAW on r5, released by same-cycle writeback
        step(1, 4'd0, 4'd0, 4'd0, 1, 4'd5, 1, 0, 4'd0, 32'd0, 0);
        step(1, 4'd5, 4'd0, 4'd0, 0, 4'd0, 1, 0, 4'd0, 32'd0, 0);
        step(1, 4'd5, 4'd0, 4'd0, 0, 4'd0, 1, 0, 4'd0, 32'd0, 0);
        step(1, 4'd5, 4'd0, 4'd0, 0, 4'd0, 1, 1, 4'd5, 32'h0000_DEAD, 0);
        chk("raw out_data_ra", out_data_ra, 32'h0000_DEAD);
        idle(1'b1);

        // WAW on r7; set+clear in one cycle leaves r7 pending
        step(1, 4'd0, 4'd0, 4'd0, 1, 4'd7, 1, 0, 4'd0, 32'd0, 0);
        step(1, 4'd0, 4'd0, 4'd0, 1, 4'd7, 1, 0, 4'd0, 32'd0, 0);
        step(1, 4'd0, 4'd0, 4'd0, 1, 4'd7, 1, 1, 4'd7, 32'h1111_0007, 0);
        step(1, 4'd7, 4'd0, 4'd0, 0, 4'd0, 1, 0, 4'd0, 32'd0, 0);
        step(1, 4'd7, 4'd0, 4'd0, 0, 4'd0, 1, 1, 4'd7, 32'h2222_0007, 0);
        idle(1'b1);

        // r0 as source and destination never stalls
        step(1, 4'd0, 4'd0, 4'd0, 1, 4'd0, 1, 0, 4'd0, 32'd0, 0);
        step(1, 4'd0, 4'd0, 4'd0, 1, 4'd0, 1, 0, 4'd0, 32'd0, 0);
        idle(1'b1);

        // flush keeps the flushed op's destination pending
        step(1, 4'd1, 4'd1, 4'd1, 1, 4'd3, 0, 0, 4'd0, 32'd0, 0);
        step(1, 4'd2, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 32'd0, 1);
        step(1, 4'd3, 4'd0, 4'd0, 0, 4'd0, 1, 0, 4'd0, 32'd0, 0);
        step(0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 1, 1, 4'd3, 32'h3333_0003, 0);
        idle(1'b1);

        // randomized traffic; writebacks only target pending registers
        for (int n = 0; n < 400; n++) begin
            logic        wv;
            logic [3:0]  ws;
            int          cnt, k;
            cnt = 0;
            for (int i = 1; i < 16; i++) if (m_pend[i]) cnt++;
            wv = 1'b0; ws = 4'd0;
            if (cnt > 0 && $urandom_range(2) == 0) begin
                k = $urandom_range(cnt - 1);
                for (int i = 1; i < 16; i++) begin
                    if (m_pend[i]) begin
                        if (k == 0) begin wv = 1'b1; ws = 4'(i); end
                        k--;
                    end
                end
            end
            step($urandom_range(3) != 0, 4'($urandom_range(7)), 4'($urandom_range(7)),
                 4'($urandom_range(7)), $urandom_range(1) == 1, 4'($urandom_range(7)),
                 $urandom_range(9) < 7, wv, ws, $urandom, $urandom_range(24) == 0);
        end
        idle(1'b1);

        // writeback to a register with nothing pending: written, error is sticky
        step(0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 1, 1, 4'd9, 32'h9999_0009, 0);
        idle(1'b1);
        chk("sb_err sticky", sb_err, 1'b1);

        // stall with the source register rewritten underneath the held op
        step(1, 4'd2, 4'd3, 4'd4, 0, 4'd0, 1, 0, 4'd0, 32'd0, 0);
        idle(1'b0);
        step(0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd2, 32'h0000_BEEF, 0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // reset in the middle of a held op clears the scoreboard
        step(1, 4'd1, 4'd0, 4'd0, 1, 4'd6, 1, 0, 4'd0, 32'd0, 0);
        idle(1'b0);
        idle(1'b0);
        apply_reset();
        step(1, 4'd6, 4'd0, 4'd0, 1, 4'd6, 1, 0, 4'd0, 32'd0, 0);
        idle(1'b1);
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
